led_framebuf: RTL and testbench
===============================

# led_framebuf

Dual-port frame buffer feeding the LED matrix panel controller. Upstream logic writes single pixels (x, y, RGB) over a valid/ready stream. The block packs them into the upper-half/lower-half word format the panel controller reads: one 48-bit word carries the two pixels that are shifted out together. A bulk clear command fills the whole buffer with one colour.

## Interface
Parameters:
- pixel_depth, 8, bits per colour channel
- panel_width, 64, pixels per row; x width = 6
- panel_height, 32, rows; y width = 5; half height = 16
- addr_width, 10, word address width (panel_width * panel_height/2 = 1024 words)
- data_width, 6*pixel_depth = 48, word width

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- px_valid  in  1  pixel write request
- px_ready  out  1  block accepts a pixel this cycle
- px_x  in  6  column 0..63
- px_y  in  5  row 0..31
- px_rgb  in  24  {r[23:16], g[15:8], b[7:0]}
- px_last  in  1  marks the final pixel of a frame
- clr_req  in  1  start bulk clear (level, sampled in IDLE)
- clr_rgb  in  24  fill colour, latched when clear starts
- busy  out  1  clear in progress
- frame_done  out  1  one-cycle pulse after the px_last pixel is committed
- rd_addr  in  10  panel-controller read address
- rd_data  out  48  {upper pixel rgb[47:24], lower pixel rgb[23:0]}

## Operation
- Storage: 1024 x 48 RAM. Port A does read-modify-write for this block. Port B is read-only for the panel controller.
- Mapping: word address = {px_y[3:0], px_x[5:0]}.
  - px_y[4]=0 → pixel goes to bits [47:24].
  - px_y[4]=1 → pixel goes to bits [23:0].
  - The other half of the word is preserved.
- FSM states: IDLE, MERGE, CLEAR.
- IDLE:
  - px_ready=1 only when clr_req=0.
  - clr_req=1 → latch clr_rgb, clear address counter = 0, go to CLEAR. A clear takes priority over a simultaneous px_valid; that pixel is not accepted.
  - px_valid & px_ready → latch x, y, rgb, last; present the word address to port A; go to MERGE.
- MERGE:
  - Port A read data is the current word. Replace the selected half with the latched rgb and write it back to the same address.
  - Set the frame_done flag if last=1.
  - Go to IDLE.
- CLEAR:
  - Write {clr_rgb, clr_rgb} to the counter address each cycle, counter +1, for addresses 0..1023.
  - Leave CLEAR after writing 1023; the counter wraps to 0. Go to IDLE.
  - busy=1 throughout CLEAR; px_ready=0.
- Port B: synchronous read. rd_data is registered from rd_addr. Read-first on a same-address collision with a port A write: rd_data returns the old word.
- Back-to-back pixels in the same word are safe. The write commits before the next read is issued, so no forwarding is needed.

## Timing
- Reset values: px_ready=0 during rst, busy=0, frame_done=0, rd_data=0, state=IDLE, clear counter=0.
- RAM contents are not cleared by rst.
- First cycle after rst deasserts: IDLE with px_ready=1 (if clr_req=0).
- Pixel accepted at edge T:
  - MERGE during T..T+1.
  - Merged word written at edge T+1.
  - px_ready=1 again after T+1.
- Throughput: 1 pixel per 2 cycles, with px_ready toggling 1,0,1,0 under continuous px_valid.
- frame_done: high for exactly one cycle, the cycle after the px_last write edge.
- Clear: clr_req sampled at edge T.
  - busy=1 from T for 1024 cycles.
  - Writes at edges T+1..T+1024.
  - busy=0 and px_ready=1 after edge T+1024.
  - clr_req held high at the end of a clear starts another clear immediately.
- rd_data latency: 1 cycle from rd_addr. Port B is unaffected by FSM state.
- rst mid-MERGE: the pending write is dropped and frame_done is not pulsed.
- rst mid-CLEAR: the clear aborts; words already written keep clr_rgb; busy=0 next cycle.
- Changes on px_x/px_y/px_rgb while px_ready=0 are ignored.

## Test plan
- Reset, then write (x=5, y=3, rgb=0x112233) → rd_addr=0x0C5 gives rd_data=0x112233_000000 one cycle after the address.
- Write (5,19,0xAABBCC) after the previous write → word 0x0C5 = 0x112233_AABBCC; the upper half is preserved.
- Continuous px_valid over 4 pixels → px_ready pattern 1,0,1,0,1,0,1. All 4 words correct.
- px_last=1 on the 4th pixel → frame_done high for exactly one cycle, 2 cycles after acceptance.
- clr_req with clr_rgb=0x0F0F0F and px_valid both high in the same IDLE cycle:
  - Expect busy for 1024 cycles, the pixel not accepted, and px_ready=0 throughout.
  - Then every address reads 0x0F0F0F_0F0F0F.
- rst asserted at clear cycle 500 → busy=0 next cycle; addresses 0..498 hold the fill colour; the high addresses are unchanged. Port B read of the address being written in the same cycle returns the old word.

Source files
------------

// File: rtl/led_framebuf_if.sv
// Pixel-write stream, clear command and panel read port of the LED frame buffer.
// The master side is the upstream pixel source / panel controller; the slave is the buffer.
interface led_framebuf_if #(
    parameter int pixel_depth  = 8,
    parameter int panel_width  = 64,
    parameter int panel_height = 32
);
    localparam int x_width    = $clog2(panel_width);
    localparam int y_width    = $clog2(panel_height);
    localparam int addr_width = x_width + y_width - 1;
    localparam int rgb_width  = 3 * pixel_depth;
    localparam int data_width = 6 * pixel_depth;

    logic                  px_valid;
    logic                  px_ready;
    logic [x_width-1:0]    px_x;
    logic [y_width-1:0]    px_y;
    logic [rgb_width-1:0]  px_rgb;
    logic                  px_last;
    logic                  clr_req;
    logic [rgb_width-1:0]  clr_rgb;
    logic                  busy;
    logic                  frame_done;
    logic [addr_width-1:0] rd_addr;
    logic [data_width-1:0] rd_data;

    modport master (
        output px_valid, px_x, px_y, px_rgb, px_last,
        output clr_req, clr_rgb, rd_addr,
        input  px_ready, busy, frame_done, rd_data
    );

    modport slave (
        input  px_valid, px_x, px_y, px_rgb, px_last,
        input  clr_req, clr_rgb, rd_addr,
        output px_ready, busy, frame_done, rd_data
    );
endinterface

// File: rtl/led_framebuf.sv
// Dual-port LED panel frame buffer: packs upper/lower-half pixels into 48-bit words
// with read-modify-write on port A, bulk clear, and a registered read port B.
module led_framebuf #(
    parameter int pixel_depth  = 8,
    parameter int panel_width  = 64,
    parameter int panel_height = 32
) (
    input  logic              clk,
    input  logic              rst,
    led_framebuf_if.slave     bus
);
    localparam int x_width    = $clog2(panel_width);
    localparam int y_width    = $clog2(panel_height);
    localparam int addr_width = x_width + y_width - 1;
    localparam int rgb_width  = 3 * pixel_depth;
    localparam int data_width = 6 * pixel_depth;
    localparam int depth      = 1 << addr_width;

    typedef enum logic [1:0] {IDLE, MERGE, CLEAR} state_t;

    state_t                state;
    state_t                state_n;
    logic [addr_width-1:0] clr_cnt;
    logic [rgb_width-1:0]  fill_rgb;
    logic [addr_width-1:0] lat_addr;
    logic                  lat_half;
    logic [rgb_width-1:0]  lat_rgb;
    logic                  lat_last;
    logic                  frame_q;

    logic [data_width-1:0] mem [depth];
    logic [data_width-1:0] a_rdata;
    logic [data_width-1:0] rd_q;

    logic                  we;
    logic [addr_width-1:0] wr_addr;
    logic [data_width-1:0] wr_data;
    logic                  accept;
    logic                  start_clr;
    logic                  ready;
    logic [addr_width-1:0] px_addr;

    assign px_addr        = {bus.px_y[y_width-2:0], bus.px_x};
    assign bus.px_ready   = ready;
    assign bus.busy       = (state == CLEAR);
    assign bus.frame_done = frame_q;
    assign bus.rd_data    = rd_q;

    // Next-state and port-A write control; rst suppresses any pending write.
    always_comb begin
        state_n   = state;
        we        = 1'b0;
        wr_addr   = lat_addr;
        wr_data   = a_rdata;
        accept    = 1'b0;
        start_clr = 1'b0;
        ready     = 1'b0;
        unique case (state)
            IDLE: begin
                ready = !rst && !bus.clr_req;
                if (bus.clr_req) begin
                    start_clr = 1'b1;
                    state_n   = CLEAR;
                end else if (bus.px_valid) begin
                    accept  = 1'b1;
                    state_n = MERGE;
                end
            end
            MERGE: begin
                we = !rst;
                if (lat_half)
                    wr_data = {a_rdata[data_width-1:rgb_width], lat_rgb};
                else
                    wr_data = {lat_rgb, a_rdata[rgb_width-1:0]};
                state_n = IDLE;
            end
            CLEAR: begin
                we      = !rst;
                wr_addr = clr_cnt;
                wr_data = {fill_rgb, fill_rgb};
                if (&clr_cnt)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Control state: FSM, clear counter and the frame-done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
            frame_q <= 1'b0;
        end else begin
            state   <= state_n;
            frame_q <= (state == MERGE) && lat_last;
            if (start_clr)
                clr_cnt <= '0;
            else if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Capture the accepted pixel and the fill colour; no reset needed.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lat_addr <= px_addr;
            lat_half <= bus.px_y[y_width-1];
            lat_rgb  <= bus.px_rgb;
            lat_last <= bus.px_last;
        end
        if (start_clr && !rst)
            fill_rgb <= bus.clr_rgb;
    end

    // Port A: write plus read of the incoming pixel's word for the merge.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        a_rdata <= mem[px_addr];
    end

    // Port B: registered read-first read for the panel controller.
    always_ff @(posedge clk) begin
        if (rst)
            rd_q <= '0;
        else
            rd_q <= mem[bus.rd_addr];
    end
endmodule

// File: tb/tb_led_framebuf.sv
// Directed self-checking bench for led_framebuf: pixel merge, burst handshake,
// frame_done pulse, bulk clear and reset during clear.
module tb_led_framebuf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    led_framebuf_if bus ();

    led_framebuf dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [9:0] a, input logic [47:0] exp, input string tag);
        bus.rd_addr = a;
        tick();
        chk(tag, bus.rd_data, exp);
    endtask

    logic [5:0]  bx   [4] = '{6'd0, 6'd1, 6'd2, 6'd63};
    logic [4:0]  by   [4] = '{5'd0, 5'd0, 5'd16, 5'd31};
    logic [23:0] brgb [4] = '{24'h010203, 24'h040506, 24'h070809, 24'hFFEEDD};

    initial begin
        bus.px_valid = 1'b0;
        bus.px_x     = '0;
        bus.px_y     = '0;
        bus.px_rgb   = '0;
        bus.px_last  = 1'b0;
        bus.clr_req  = 1'b0;
        bus.clr_rgb  = '0;
        bus.rd_addr  = '0;

        // bring the RAM to a known all-zero state
        tick();
        tick();
        rst = 1'b0;
        bus.clr_req = 1'b1;
        tick();
        bus.clr_req = 1'b0;
        repeat (1024) tick();

        // reset values
        rst = 1'b1;
        tick();
        tick();
        chk("rst_px_ready", {47'd0, bus.px_ready}, 48'd0);
        chk("rst_busy", {47'd0, bus.busy}, 48'd0);
        chk("rst_frame_done", {47'd0, bus.frame_done}, 48'd0);
        chk("rst_rd_data", bus.rd_data, 48'd0);
        rst = 1'b0;
        #1;
        chk("idle_px_ready", {47'd0, bus.px_ready}, 48'd1);

        // upper-half write
        bus.px_valid = 1'b1;
        bus.px_x = 6'd5;
        bus.px_y = 5'd3;
        bus.px_rgb = 24'h112233;
        tick();
        bus.px_valid = 1'b0;
        chk("merge_ready_low", {47'd0, bus.px_ready}, 48'd0);
        tick();
        chk("merge_ready_back", {47'd0, bus.px_ready}, 48'd1);
        rd(10'h0C5, 48'h112233_000000, "upper_write");

        // lower-half write preserves upper half
        bus.px_valid = 1'b1;
        bus.px_y = 5'd19;
        bus.px_rgb = 24'hAABBCC;
        tick();
        bus.px_valid = 1'b0;
        tick();
        rd(10'h0C5, 48'h112233_AABBCC, "lower_merge");

        // burst of 4 pixels under continuous px_valid
        bus.px_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.px_x = bx[i];
            bus.px_y = by[i];
            bus.px_rgb = brgb[i];
            bus.px_last = (i == 3);
            #1;
            chk("burst_ready_hi", {47'd0, bus.px_ready}, 48'd1);
            tick();
            chk("burst_ready_lo", {47'd0, bus.px_ready}, 48'd0);
            chk("burst_no_done", {47'd0, bus.frame_done}, 48'd0);
            bus.px_x = 6'd7;
            bus.px_y = 5'd7;
            bus.px_rgb = 24'hDEADBE;
            bus.px_last = 1'b0;
            if (i == 3)
                bus.px_valid = 1'b0;
            tick();
        end
        chk("frame_done_hi", {47'd0, bus.frame_done}, 48'd1);
        chk("burst_ready_end", {47'd0, bus.px_ready}, 48'd1);
        tick();
        chk("frame_done_lo", {47'd0, bus.frame_done}, 48'd0);
        rd(10'h000, 48'h010203_000000, "burst_w0");
        rd(10'h001, 48'h040506_000000, "burst_w1");
        rd(10'h002, 48'h000000_070809, "burst_w2");
        rd(10'h3FF, 48'h000000_FFEEDD, "burst_w3");
        rd(10'h1C7, 48'h000000_000000, "ignored_data");

        // clear wins over a simultaneous pixel
        bus.px_valid = 1'b1;
        bus.px_x = 6'd10;
        bus.px_y = 5'd10;
        bus.px_rgb = 24'h123456;
        bus.clr_req = 1'b1;
        bus.clr_rgb = 24'h0F0F0F;
        #1;
        chk("clr_ready_low", {47'd0, bus.px_ready}, 48'd0);
        tick();
        bus.clr_req = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            chk("clr_busy", {46'd0, bus.busy, bus.px_ready}, 48'd2);
            tick();
        end
        chk("clr_end_busy", {47'd0, bus.busy}, 48'd0);
        chk("clr_end_ready", {47'd0, bus.px_ready}, 48'd1);
        bus.px_valid = 1'b0;
        for (int a = 0; a < 1024; a++)
            rd(a[9:0], 48'h0F0F0F_0F0F0F, "clr_fill");

        // reset during clear cycle 500, with a read-first collision just before
        bus.clr_req = 1'b1;
        bus.clr_rgb = 24'h5A5A5A;
        tick();
        bus.clr_req = 1'b0;
        repeat (498) tick();
        bus.rd_addr = 10'd498;
        tick();
        chk("collision_old", bus.rd_data, 48'h0F0F0F_0F0F0F);
        chk("abort_busy_pre", {47'd0, bus.busy}, 48'd1);
        rst = 1'b1;
        tick();
        chk("abort_busy", {47'd0, bus.busy}, 48'd0);
        chk("abort_rd_zero", bus.rd_data, 48'd0);
        rst = 1'b0;
        rd(10'd0, 48'h5A5A5A_5A5A5A, "abort_lo0");
        rd(10'd250, 48'h5A5A5A_5A5A5A, "abort_mid");
        rd(10'd498, 48'h5A5A5A_5A5A5A, "abort_last");
        rd(10'd499, 48'h0F0F0F_0F0F0F, "abort_499");
        rd(10'd500, 48'h0F0F0F_0F0F0F, "abort_500");
        rd(10'd1023, 48'h0F0F0F_0F0F0F, "abort_top");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
